// File: rtl/uart_rx.sv
// UART receive control: 2-flop input synchroniser, 16x oversampled frame FSM,
// first-word fall-through receive FIFO and sticky error flags.
module uart_rx #(
  parameter int UART_DATA_WIDTH        = 8,
  parameter int UART_RX_FIFO_DEPTH     = 8,
  parameter int UART_RX_FIFO_PTR_WIDTH = 4
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic                       rx_sample_pulse,
  input  logic                       UART_RX,
  input  logic                       data_bits,
  input  logic                       parity_en,
  input  logic                       parity_odd0_even1,
  input  logic                       rx_data_reg_rd,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_valid,
  output logic                       parity_err,
  output logic                       framing_err,
  output logic                       overflow_err,
  input  logic                       err_clr
);

  localparam int AW = $clog2(UART_RX_FIFO_DEPTH);
  localparam int PW = UART_RX_FIFO_PTR_WIDTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                       sync1_q, rx_s_q;
  logic [2:0]                 state_q, state_d;
  logic [3:0]                 sample_cnt_q, sample_cnt_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                       par_bad_q, par_bad_d;
  logic                       brk_q, brk_d;
  logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic                       parity_err_q, parity_err_d;
  logic                       framing_err_q, framing_err_d;
  logic                       overflow_err_q, overflow_err_d;
  logic [UART_DATA_WIDTH-1:0] mem_q [UART_RX_FIFO_DEPTH];

  logic       push_req, ferr_set, fifo_full, fifo_empty, pop, push_ok, ovf_set, perr_set;
  logic       par_exp;
  logic [2:0] last_bit;

  assign last_bit = data_bits ? 3'd7 : 3'd6;
  assign par_exp  = parity_odd0_even1 ? (^shreg_q) : (~^shreg_q);

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    brk_d        = brk_q;
    push_req     = 1'b0;
    ferr_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sample_cnt_d = 4'd0;
        // After a break the line must return high before a new start is accepted
        if (brk_q) begin
          if (rx_s_q) brk_d = 1'b0;
        end else if (!rx_s_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_sample_pulse) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd7) begin
            sample_cnt_d = 4'd0;
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              bit_cnt_d = 3'd0;
              shreg_d   = '0;
              par_bad_d = 1'b0;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_sample_pulse) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            shreg_d[bit_cnt_q] = rx_s_q;
            // >= keeps the FSM terminating if data_bits changes mid-frame
            if (bit_cnt_q >= last_bit) begin
              state_d      = parity_en ? ST_PARITY : ST_STOP;
              sample_cnt_d = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
      end
      ST_PARITY: begin
        if (rx_sample_pulse) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            if (rx_s_q != par_exp) par_bad_d = 1'b1;
            state_d      = ST_STOP;
            sample_cnt_d = 4'd0;
          end
        end
      end
      ST_STOP: begin
        if (rx_sample_pulse) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            state_d      = ST_IDLE;
            sample_cnt_d = 4'd0;
            if (rx_s_q) begin
              push_req = 1'b1;
            end else begin
              ferr_set = 1'b1;
              brk_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        sample_cnt_d = 4'd0;
      end
    endcase
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = rx_data_reg_rd && !fifo_empty;
  // A full FIFO still accepts a byte when the head is popped in the same cycle
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign perr_set   = push_req && par_bad_q;

  always_comb begin
    wptr_d         = wptr_q + {{(PW-1){1'b0}}, push_ok};
    rptr_d         = rptr_q + {{(PW-1){1'b0}}, pop};
    parity_err_d   = perr_set ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
    framing_err_d  = ferr_set ? 1'b1 : (err_clr ? 1'b0 : framing_err_q);
    overflow_err_d = ovf_set  ? 1'b1 : (err_clr ? 1'b0 : overflow_err_q);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      state_q        <= ST_IDLE;
      sample_cnt_q   <= 4'd0;
      bit_cnt_q      <= 3'd0;
      shreg_q        <= '0;
      par_bad_q      <= 1'b0;
      brk_q          <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      parity_err_q   <= 1'b0;
      framing_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      sync1_q        <= UART_RX;
      rx_s_q         <= sync1_q;
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      par_bad_q      <= par_bad_d;
      brk_q          <= brk_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      parity_err_q   <= parity_err_d;
      framing_err_q  <= framing_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  assign rx_valid     = !fifo_empty;
  assign rx_data      = fifo_empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign parity_err   = parity_err_q;
  assign framing_err  = framing_err_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written overflow, break,
// glitch and mid-frame reset sequences. One bit time = 16 pulses = 64 PCLKs.
module tb_uart_rx;
  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       rx_sample_pulse = 1'b0;
  logic       UART_RX = 1'b1;
  logic       data_bits = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd0_even1 = 1'b0;
  logic       rx_data_reg_rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, overflow_err;

  int n_cmp = 0;
  int n_bad = 0;
  int div = 0;

  uart_rx dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .rx_sample_pulse(rx_sample_pulse),
    .UART_RX(UART_RX), .data_bits(data_bits), .parity_en(parity_en),
    .parity_odd0_even1(parity_odd0_even1), .rx_data_reg_rd(rx_data_reg_rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .framing_err(framing_err), .overflow_err(overflow_err), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  // 16x strobe: one PCLK in every four
  always @(negedge PCLK) begin
    div = (div + 1) % 4;
    rx_sample_pulse = (div == 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] din;
    logic       db;
    logic       pen;
    logic       peven;
    logic       pbit;
    logic       sbit;
    logic       ev;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic sbit);
    @(negedge PCLK);
    UART_RX = 1'b0;
    repeat (64) @(negedge PCLK);
    for (int i = 0; i < nbits; i++) begin
      UART_RX = d[i];
      repeat (64) @(negedge PCLK);
    end
    if (pen) begin
      UART_RX = pbit;
      repeat (64) @(negedge PCLK);
    end
    UART_RX = sbit;
    repeat (64) @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, rx_valid, 1'b1);
    check({name, "_data"}, rx_data, exp);
    $display("read: rx_data=0x%02h expected 0x%02h", rx_data, exp);
    rx_data_reg_rd = 1'b1;
    @(negedge PCLK);
    rx_data_reg_rd = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
  endtask

  task automatic set_cfg(input logic db, input logic pen, input logic peven);
    data_bits = db;
    parity_en = pen;
    parity_odd0_even1 = peven;
  endtask

  // Pops in exactly the cycle of the 8N1 stop sample: three PCLKs of
  // synchroniser/IDLE, then the 152nd counted strobe (8 start + 8*16 data + 16 stop).
  task automatic simul_pop();
    int c = 0;
    @(negedge PCLK);
    repeat (3) @(posedge PCLK);
    while (c < 151) begin
      @(posedge PCLK);
      if (rx_sample_pulse) c++;
    end
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("pp_valid", rx_valid, 1'b1);
    check("pp_head", rx_data, 8'h11);
    rx_data_reg_rd = 1'b1;
    @(negedge PCLK);
    rx_data_reg_rd = 1'b0;
  endtask

  initial begin
    //        din    db    pen   peven pbit  sbit  ev    ed     ep    ef
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0};

    repeat (4) @(negedge PCLK);
    PRESETN = 1'b1;
    idle(8);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", framing_err, 1'b0);
    check("rst_ovf", overflow_err, 1'b0);

    // Frame table
    for (int v = 0; v < 9; v++) begin
      set_cfg(vecs[v].db, vecs[v].pen, vecs[v].peven);
      send_frame(vecs[v].din, vecs[v].db ? 8 : 7, vecs[v].pen, vecs[v].pbit, vecs[v].sbit);
      idle(16);
      $display("vec %0d: din=0x%02h valid=%0b data=0x%02h perr=%0b ferr=%0b",
               v, vecs[v].din, rx_valid, rx_data, parity_err, framing_err);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].ev);
      if (vecs[v].ev) check($sformatf("vec%0d_data", v), rx_data, vecs[v].ed);
      check($sformatf("vec%0d_perr", v), parity_err, vecs[v].ep);
      check($sformatf("vec%0d_ferr", v), framing_err, vecs[v].ef);
      check($sformatf("vec%0d_ovf", v), overflow_err, 1'b0);
      if (vecs[v].ev) begin
        rx_data_reg_rd = 1'b1;
        @(negedge PCLK);
        rx_data_reg_rd = 1'b0;
        check($sformatf("vec%0d_empty", v), rx_valid, 1'b0);
      end
      clear_errs();
      check($sformatf("vec%0d_perr_clr", v), parity_err, 1'b0);
      check($sformatf("vec%0d_ferr_clr", v), framing_err, 1'b0);
    end

    // Read while empty must not move the pointers
    rx_data_reg_rd = 1'b1;
    @(negedge PCLK);
    rx_data_reg_rd = 1'b0;
    check("rd_empty_valid", rx_valid, 1'b0);

    // Overflow: nine frames, no reads
    set_cfg(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      send_frame(k[7:0], 8, 1'b0, 1'b0, 1'b1);
      idle(16);
    end
    check("ovf_set", overflow_err, 1'b1);
    for (int k = 1; k <= 8; k++) pop_check($sformatf("ovf_rd%0d", k), k[7:0]);
    check("ovf_drained", rx_valid, 1'b0);
    clear_errs();
    check("ovf_clr", overflow_err, 1'b0);

    // Fill again, then push and pop in the same cycle while full
    for (int k = 1; k <= 8; k++) begin
      send_frame(8'h10 + k[7:0], 8, 1'b0, 1'b0, 1'b1);
      idle(16);
    end
    check("full_no_ovf", overflow_err, 1'b0);
    fork
      send_frame(8'h19, 8, 1'b0, 1'b0, 1'b1);
      simul_pop();
    join
    idle(16);
    check("pp_no_ovf", overflow_err, 1'b0);
    for (int k = 2; k <= 9; k++) pop_check($sformatf("pp_rd%0d", k), 8'h10 + k[7:0]);
    check("pp_drained", rx_valid, 1'b0);

    // Break: stop bit low and line held low
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
    repeat (20 * 64) @(negedge PCLK);
    check("brk_ferr", framing_err, 1'b1);
    check("brk_valid", rx_valid, 1'b0);
    clear_errs();
    repeat (12 * 64) @(negedge PCLK);
    check("brk_no_restart", framing_err, 1'b0);
    idle(64);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("brk_after_ferr", framing_err, 1'b0);
    pop_check("brk_after", 8'h96);

    // Glitch shorter than half a bit
    @(negedge PCLK);
    UART_RX = 1'b0;
    repeat (16) @(negedge PCLK);
    idle(200);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_ferr", framing_err, 1'b0);
    check("glitch_perr", parity_err, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    idle(16);
    pop_check("glitch_after", 8'h5A);

    // Mid-frame reset with a byte queued and a flag set
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    idle(16);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
    idle(16);
    check("pre_rst_valid", rx_valid, 1'b1);
    check("pre_rst_ferr", framing_err, 1'b1);
    @(negedge PCLK);
    UART_RX = 1'b0;
    repeat (192) @(negedge PCLK);
    PRESETN = 1'b0;
    #1;
    check("mrst_valid", rx_valid, 1'b0);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_ferr", framing_err, 1'b0);
    check("mrst_perr", parity_err, 1'b0);
    check("mrst_ovf", overflow_err, 1'b0);
    UART_RX = 1'b1;
    repeat (4) @(negedge PCLK);
    PRESETN = 1'b1;
    idle(16);
    check("post_rst_valid", rx_valid, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    idle(16);
    pop_check("post_rst", 8'h3C);
    check("post_rst_empty", rx_valid, 1'b0);
    check("post_rst_ferr", framing_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
